decode_queue: RTL
=================

# decode_queue

Parametrised decode stage with elastic buffering. Decodes one RV32I instruction per cycle into an `rv32i_control_word` plus mux selects, flags illegal encodings, and holds decoded entries in a `DEPTH`-entry circular FIFO. The FIFO decouples fetch from the execute-side stall logic. It sits between the IF/ID boundary and the ID/EX register and supports pipeline flush and inserted bubbles.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered entries.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: queue accepts the offered instruction.
- `in_instr` in 32: raw instruction word.
- `in_pc` in 32: PC of `in_instr`.
- `in_bubble` in 1: entry is an inserted NOP; decode suppressed.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes the head entry.
- `out_ctrl` out `rv32i_control_word`: decoded control word.
- `out_alumux1_sel` out `alumux1_sel_t`: ALU operand-1 select.
- `out_alumux2_sel` out `alumux2_sel_t`: ALU operand-2 select.
- `out_cmpmux_sel` out `cmpmux_sel_t`: comparator operand select.
- `out_pc` out 32: PC of the head entry.
- `out_illegal` out 1: head entry is an illegal encoding.
- `count` out `CNT_W`: number of occupied entries.

## Operation
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (count != DEPTH)`, which is registered-state only with no combinational path from `out_ready`.
- **Pop:** occurs when `out_valid && out_ready`. `out_valid = (count != 0)`.
- **Decode at enqueue:**
  - `u_imm = {in_instr[31:12], 12'h0}`.
  - Opcode semantics: lui, auipc, jal, jalr, br, load, store, op_imm, op_reg decode exactly as the current control ROM, including slt/sltu via the comparator and the funct7[5] sub/sra selection.
  - Default control: `load_regfile=0`, `read=0`, `write=0`, `aluop=alu_add`, `pcmux=pc_plus4`, `regfilemux=alu_out`.
- **Illegal encodings:** set `illegal=1` and force ctrl to all-zero. The following are illegal:
  - Unknown opcode.
  - Load funct3 ∈ {3,6,7}.
  - Store funct3 > 2.
  - Branch funct3 ∈ {2,3}.
  - op_imm slli funct7 ≠ 0.
  - op_imm sr funct7 ∉ {0x00,0x20}.
  - op_reg funct7 ∉ {0x00,0x20}.
  - op_reg funct7 = 0x20 with funct3 ∉ {add,sr}.
- **Bubble:** `in_bubble=1` stores the default control word with `load_regfile=0`, `read=0`, `write=0` and `illegal=0`, regardless of `in_instr`.
- **Pointers:** head/tail are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- **Simultaneous events:**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when full: push is still refused that cycle, because `in_ready` was 0.
  - `flush` has priority over push and pop. Head, tail and count go to 0, and any push that cycle is dropped.
- **Reset:** `rst` takes effect mid-operation identically to `flush` and aborts all entries.

## Timing
- Latency: an entry pushed in cycle N is visible on `out_*` in cycle N+1. There is no bypass.
- Outputs are driven from registered storage and head pointer only.
- Reset values:
  - `count=0`, `out_valid=0`, `in_ready=1`, `out_illegal=0`.
  - `out_ctrl`, `out_pc` and the mux selects read entry 0. Entry storage is not reset, so consumers must qualify these outputs with `out_valid`.
- After `flush` in cycle N: `out_valid=0` and `in_ready=1` in cycle N+1.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- **`RV32M_EN` defined:** op_reg with funct7 = 0x01 is legal.
  - Sets `ctrl.muldiv_en=1` and `ctrl.muldiv_op=muldiv_funct3_t'(funct3)`.
  - Sets `load_regfile=1` and `regfilemux=alu_out`.
- **`RV32M_EN` undefined:** funct7 = 0x01 is illegal, and the `muldiv_*` ctrl fields are absent.

## Structure
- `rv32i_types` additions:
  - `decode_entry_t` struct (ctrl, three mux selects, pc, illegal).
  - `muldiv_funct3_t`, plus the `muldiv_*` ctrl fields, both under `RV32M_EN`.
  - `FUNCT7_BASE=7'h00`, `FUNCT7_ALT=7'h20`, `FUNCT7_MULDIV=7'h01`.
- Sub-module `rv32i_decoder`: purely combinational, taking instr and bubble and returning a `decode_entry_t` minus pc. It is instantiated once at the FIFO write port.

## Test plan
- **Reset then single decode:** after reset, push `add x3,x1,x2` (0x002081B3) → one cycle later `out_valid=1`, `aluop=alu_add`, `load_regfile=1`, `rd=3`, `alumux2=rs2_out`.
- **Illegal detection:** push 0x0000007F, then push load funct3=3 (0x0000B003) → both dequeue with `out_illegal=1` and ctrl all-zero.
- **Fill and backpressure (DEPTH=4):** hold `out_ready=0` and push 5 instructions → `in_ready=0` after the 4th, `count=4`, the 5th is not accepted. Then pop 4 → original order preserved and pointers wrap.
- **Simultaneous push/pop at count=2:** count stays 2 over 10 cycles and the output order matches input order.
- **Flush with concurrent push:** flush while `count=3` and `in_valid=1` → next cycle `count=0`, `out_valid=0`, and the pushed entry never appears.
- **Bubble and `RV32M_EN`:** push `mul` (0x022081B3) with `in_bubble=1` → ctrl default, `illegal=0`. Push it with `in_bubble=0` → `muldiv_en=1` when the macro is defined, `out_illegal=1` when it is undefined.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types: control word, mux selects and the queued decode entry.
// Optional RV32M support is enabled by defining RV32M_EN.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // Encodings chosen so the default control word is all-zero.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    pc_plus4    = 2'd0,
    pc_alu      = 2'd1,
    pc_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic [3:0] {
    alu_out     = 4'd0,
    br_en       = 4'd1,
    rf_u_imm    = 4'd2,
    lw          = 4'd3,
    rf_pc_plus4 = 4'd4,
    lb          = 4'd5,
    lbu         = 4'd6,
    lh          = 4'd7,
    lhu         = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    rs1_out = 1'b0,
    pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    i_imm   = 3'd0,
    u_imm   = 3'd1,
    b_imm   = 3'd2,
    s_imm   = 3'd3,
    j_imm   = 3'd4,
    rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic {
    cmp_rs2_out = 1'b0,
    cmp_i_imm   = 1'b1
  } cmpmux_sel_t;

`ifdef RV32M_EN
  typedef enum logic [2:0] {
    md_mul    = 3'd0,
    md_mulh   = 3'd1,
    md_mulhsu = 3'd2,
    md_mulhu  = 3'd3,
    md_div    = 3'd4,
    md_divu   = 3'd5,
    md_rem    = 3'd6,
    md_remu   = 3'd7
  } muldiv_funct3_t;
`endif

  localparam logic [6:0] FUNCT7_BASE   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_SR   = 3'd5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            load_regfile;
    logic            read;
    logic            write;
    pcmux_sel_t      pcmux;
    regfilemux_sel_t regfilemux;
`ifdef RV32M_EN
    logic            muldiv_en;
    muldiv_funct3_t  muldiv_op;
`endif
  } rv32i_control_word;

  typedef struct packed {
    rv32i_control_word ctrl;
    alumux1_sel_t      alumux1_sel;
    alumux2_sel_t      alumux2_sel;
    cmpmux_sel_t       cmpmux_sel;
    logic [31:0]       pc;
    logic              illegal;
  } decode_entry_t;

endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I decoder feeding the queue write port; RV32M_EN adds M-extension
// decode. Illegal encodings produce an all-zero control word with illegal set.
module rv32i_decoder
  import rv32i_types::*;
(
  input  logic [31:0]       instr,
  input  logic              bubble,
  output rv32i_control_word ctrl,
  output alumux1_sel_t      alumux1_sel,
  output alumux2_sel_t      alumux2_sel,
  output cmpmux_sel_t       cmpmux_sel,
  output logic              illegal
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{21{instr[31]}}, instr[30:20]};
  assign imm_s  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl              = '0;
    ctrl.aluop        = alu_add;
    ctrl.cmpop        = beq;
    ctrl.pcmux        = pc_plus4;
    ctrl.regfilemux   = alu_out;
    ctrl.load_regfile = 1'b0;
    ctrl.read         = 1'b0;
    ctrl.write        = 1'b0;
    alumux1_sel       = rs1_out;
    alumux2_sel       = i_imm;
    cmpmux_sel        = cmp_rs2_out;
    illegal           = 1'b0;

    if (!bubble) begin
      ctrl.opcode = rv32i_opcode'(instr[6:0]);
      ctrl.funct3 = funct3;
      ctrl.funct7 = funct7;
      ctrl.rs1    = instr[19:15];
      ctrl.rs2    = instr[24:20];
      ctrl.rd     = instr[11:7];

      case (instr[6:0])
        op_lui: begin
          ctrl.imm          = imm_u;
          ctrl.load_regfile = 1'b1;
          ctrl.regfilemux   = rf_u_imm;
        end
        op_auipc: begin
          ctrl.imm          = imm_u;
          ctrl.load_regfile = 1'b1;
          alumux1_sel       = pc_out;
          alumux2_sel       = u_imm;
        end
        op_jal: begin
          ctrl.imm          = imm_j;
          ctrl.load_regfile = 1'b1;
          ctrl.regfilemux   = rf_pc_plus4;
          ctrl.pcmux        = pc_alu;
          alumux1_sel       = pc_out;
          alumux2_sel       = j_imm;
        end
        op_jalr: begin
          ctrl.imm          = imm_i;
          ctrl.load_regfile = 1'b1;
          ctrl.regfilemux   = rf_pc_plus4;
          ctrl.pcmux        = pc_alu_mod2;
        end
        op_br: begin
          // Target is computed by the ALU; the comparator decides taken/not-taken downstream.
          ctrl.imm    = imm_b;
          ctrl.cmpop  = branch_funct3_t'(funct3);
          alumux1_sel = pc_out;
          alumux2_sel = b_imm;
          if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
        end
        op_load: begin
          ctrl.imm          = imm_i;
          ctrl.read         = 1'b1;
          ctrl.load_regfile = 1'b1;
          case (funct3)
            F3_LB:   ctrl.regfilemux = lb;
            F3_LH:   ctrl.regfilemux = lh;
            F3_LW:   ctrl.regfilemux = lw;
            F3_LBU:  ctrl.regfilemux = lbu;
            F3_LHU:  ctrl.regfilemux = lhu;
            default: illegal = 1'b1;
          endcase
        end
        op_store: begin
          ctrl.imm    = imm_s;
          ctrl.write  = 1'b1;
          alumux2_sel = s_imm;
          if (funct3 > 3'd2) illegal = 1'b1;
        end
        op_imm: begin
          ctrl.imm          = imm_i;
          ctrl.load_regfile = 1'b1;
          case (funct3)
            F3_SLT: begin
              ctrl.cmpop      = blt;
              ctrl.regfilemux = br_en;
              cmpmux_sel      = cmp_i_imm;
            end
            F3_SLTU: begin
              ctrl.cmpop      = bltu;
              ctrl.regfilemux = br_en;
              cmpmux_sel      = cmp_i_imm;
            end
            F3_SLL: begin
              ctrl.aluop = alu_sll;
              if (funct7 != FUNCT7_BASE) illegal = 1'b1;
            end
            F3_SR: begin
              ctrl.aluop = (funct7 == FUNCT7_ALT) ? alu_sra : alu_srl;
              if (funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) illegal = 1'b1;
            end
            default: ctrl.aluop = alu_ops'(funct3);
          endcase
        end
        op_reg: begin
          ctrl.load_regfile = 1'b1;
          alumux2_sel       = rs2_out;
          if (funct7 == FUNCT7_BASE) begin
            case (funct3)
              F3_SLT: begin
                ctrl.cmpop      = blt;
                ctrl.regfilemux = br_en;
              end
              F3_SLTU: begin
                ctrl.cmpop      = bltu;
                ctrl.regfilemux = br_en;
              end
              default: ctrl.aluop = alu_ops'(funct3);
            endcase
          end else if (funct7 == FUNCT7_ALT) begin
            if (funct3 == F3_ADD)     ctrl.aluop = alu_sub;
            else if (funct3 == F3_SR) ctrl.aluop = alu_sra;
            else                      illegal = 1'b1;
`ifdef RV32M_EN
          end else if (funct7 == FUNCT7_MULDIV) begin
            ctrl.muldiv_en  = 1'b1;
            ctrl.muldiv_op  = muldiv_funct3_t'(funct3);
            ctrl.regfilemux = alu_out;
`endif
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase

      if (illegal) begin
        ctrl        = '0;
        alumux1_sel = rs1_out;
        alumux2_sel = i_imm;
        cmpmux_sel  = cmp_rs2_out;
      end
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry circular FIFO between IF/ID and ID/EX.
// Build with RV32M_EN defined to accept M-extension op_reg encodings.
module decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic              in_bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_control_word out_ctrl,
  output alumux1_sel_t      out_alumux1_sel,
  output alumux2_sel_t      out_alumux2_sel,
  output cmpmux_sel_t       out_cmpmux_sel,
  output logic [31:0]       out_pc,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  decode_entry_t     mem [DEPTH];
  decode_entry_t     wr_entry;
  decode_entry_t     head_entry;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  cnt_q;
  logic              push, pop;

  rv32i_control_word dec_ctrl;
  alumux1_sel_t      dec_alumux1_sel;
  alumux2_sel_t      dec_alumux2_sel;
  cmpmux_sel_t       dec_cmpmux_sel;
  logic              dec_illegal;

  rv32i_decoder u_decoder (
    .instr       (in_instr),
    .bubble      (in_bubble),
    .ctrl        (dec_ctrl),
    .alumux1_sel (dec_alumux1_sel),
    .alumux2_sel (dec_alumux2_sel),
    .cmpmux_sel  (dec_cmpmux_sel),
    .illegal     (dec_illegal)
  );

  always_comb begin
    wr_entry             = '0;
    wr_entry.ctrl        = dec_ctrl;
    wr_entry.alumux1_sel = dec_alumux1_sel;
    wr_entry.alumux2_sel = dec_alumux2_sel;
    wr_entry.cmpmux_sel  = dec_cmpmux_sel;
    wr_entry.pc          = in_pc;
    wr_entry.illegal     = dec_illegal;
  end

  // Handshakes depend only on the registered occupancy, never on out_ready.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage is not reset; a write during flush lands in a slot that is already discarded.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_entry;
  end

  assign head_entry      = mem[head];
  assign out_ctrl        = head_entry.ctrl;
  assign out_alumux1_sel = head_entry.alumux1_sel;
  assign out_alumux2_sel = head_entry.alumux2_sel;
  assign out_cmpmux_sel  = head_entry.cmpmux_sel;
  assign out_pc          = head_entry.pc;
  assign out_illegal     = out_valid && head_entry.illegal;
  assign count           = cnt_q;

endmodule
